// File: rtl/copy_pkg.sv
// Shared definitions for the copy engine and its memory responder:
// bus widths, the response record and the default memory base address.
package copy_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'h0000_1000;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              we;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/copy_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; the caller guarantees
// no push when full and no pop when empty.
module copy_rsp_fifo
    import copy_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [RSP_W-1:0] push_data,
    input  logic             pop,
    output logic [RSP_W-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [RSP_W-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Entry storage is not reset; count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_data;
    end

    assign head  = store[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/copy_mem_responder.sv
// Word-addressed memory target for copy_engine: valid/ready requests, fixed-latency
// in-order responses, error on misaligned/out-of-range. Optional macro: COPY_RSP_STALL_EN.
module copy_mem_responder
    import copy_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS     = 2048,
    parameter int          READ_LATENCY    = 2,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_we,
    output logic        busy
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam int          CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) << 2;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      offset;
    logic             dec_err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic             accept;
    logic             pop;
    logic             stall;
    logic             ready_en;
    logic [CW-1:0]    inflight_q;
    logic [CW-1:0]    fifo_count;
    logic [RSP_W-1:0] fifo_head;
    rsp_t             head_rsp;

    logic             vld_p  [READ_LATENCY];
    rsp_t             data_p [READ_LATENCY];

    // Addresses below BASE_ADDR wrap to a huge offset and land in the error range.
    assign offset  = req_addr - BASE_ADDR;
    assign dec_err = (req_addr[1:0] != 2'b00) | (offset >= SPAN);
    assign idx     = offset[IDX_W+1:2];
    assign accept  = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (accept & req_we & ~dec_err) mem[idx] <= req_wdata;
    end

    assign rd_word = (req_we | dec_err) ? '0 : mem[idx];

    // Stage p0: response captured at the accept edge; p1..: fixed-latency shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        data_p[0] <= '{rdata: rd_word, err: dec_err, we: req_we};
        for (int i = 1; i < READ_LATENCY; i++) data_p[i] <= data_p[i-1];
    end

    // Queue: the last pipeline stage pushes; credit keeps it from overflowing.
    copy_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p[READ_LATENCY-1]),
        .push_data (data_p[READ_LATENCY-1]),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign head_rsp  = rsp_t'(fifo_head);
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = rsp_valid ? head_rsp.rdata : '0;
    assign rsp_err   = rsp_valid & head_rsp.err;
    assign rsp_we    = rsp_valid & head_rsp.we;

    // Pipeline occupancy plus queue occupancy, tracked as one counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
            ready_en   <= 1'b0;
        end else begin
            inflight_q <= inflight_q + CW'(accept) - CW'(pop);
            ready_en   <= 1'b1;
        end
    end

`ifdef COPY_RSP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign req_ready = ready_en & (inflight_q < CW'(MAX_OUTSTANDING)) & ~stall;
    assign busy      = (inflight_q != '0);

endmodule

// File: tb/tb_copy_mem_responder.sv
// Self-checking bench for copy_mem_responder: scenario tasks plus randomized
// traffic checked against a word-array memory model and an expected-response queue.
module tb_copy_mem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 2048;
    localparam int          LAT   = 2;
    localparam int          MAXO  = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_we;
    logic        busy;

    copy_mem_responder #(
        .BASE_ADDR       (BASE),
        .DEPTH_WORDS     (DEPTH),
        .READ_LATENCY    (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_we    (rsp_we),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        we;
    } rsp_s;

    rsp_s        exp_q[$];
    rsp_s        got_q[$];
    logic [31:0] model [logic [31:0]];
    int          total;
    int          bad;
    int          acc_cnt;
    logic        rand_done;

    // Reference: decode and memory effect of one accepted request.
    task automatic model_accept(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] off;
        rsp_s        r;
        off     = addr - BASE;
        r.we    = we;
        r.err   = ((addr & 32'h3) != 0) || (off >= 32'(DEPTH * 4));
        r.rdata = 32'h0;
        if (!r.err) begin
            if (we) model[off >> 2] = wdata;
            else if (model.exists(off >> 2)) r.rdata = model[off >> 2];
        end
        exp_q.push_back(r);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst && rsp_valid && rsp_ready)
                got_q.push_back(rsp_s'({rsp_rdata, rsp_err, rsp_we}));
        end
    endtask

    // Present one request and hold it until accepted; returns 1ns after the accept edge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int   waited;
        logic ok;
        waited    = 0;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                waited++;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout addr=%h got no accept, want accept within 200 cycles", addr);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(we, addr, wdata);
            acc_cnt++;
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag);
        int w;
        w = 0;
        while ((got_q.size() < exp_q.size() || busy) && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 300) begin
            total++;
            bad++;
            $display("FAIL %s drain_timeout got=%0d want=%0d responses", tag, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        #12;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata got=%h want=0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b want=0", rsp_err); end
        total++; if (rsp_we !== 1'b0) begin bad++; $display("FAIL rst_rsp_we got=%b want=0", rsp_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b want=0", req_ready); end
        @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b want=1", req_ready); end
    endtask

    task automatic test_basic_copy();
        rsp_s        e;
        rsp_s        g;
        logic [31:0] copied [4];
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) do_req(1'b1, BASE + 32'(4 * i), 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) do_req(1'b0, BASE + 32'(4 * i), 32'h0);
        wait_drain("copy_src");
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("FAIL copy_src[%0d] got no response want one", k); end
            else begin
                g = got_q.pop_front();
                if (k >= 4) copied[k-4] = g.rdata;
                if (g !== e) begin bad++; $display("FAIL copy_src[%0d] got %h/%b/%b want %h/%b/%b", k, g.rdata, g.err, g.we, e.rdata, e.err, e.we); end
            end
        end
        for (int i = 0; i < 4; i++) do_req(1'b1, 32'h2000 + 32'(4 * i), copied[i]);
        for (int i = 0; i < 4; i++) do_req(1'b0, 32'h2000 + 32'(4 * i), 32'h0);
        wait_drain("copy_dst");
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("FAIL copy_dst[%0d] got no response want one", k); end
            else begin
                g = got_q.pop_front();
                if (k >= 4 && (g.rdata !== 32'hA0 + 32'(k - 4) || g.err !== 1'b0)) begin
                    bad++; $display("FAIL copy_dst_data[%0d] got %h err=%b want %h err=0", k - 4, g.rdata, g.err, 32'hA0 + 32'(k - 4));
                end else if (g !== e) begin
                    bad++; $display("FAIL copy_dst[%0d] got %h/%b/%b want %h/%b/%b", k, g.rdata, g.err, g.we, e.rdata, e.err, e.we);
                end
            end
        end
    endtask

    task automatic test_latency();
        logic v1, v2, v3, w3;
        logic [31:0] d3;
        rsp_ready = 1'b1;
        do_req(1'b0, 32'h1004, 32'h0);
        @(negedge clk); v1 = rsp_valid;
        @(negedge clk); v2 = rsp_valid;
        @(negedge clk); v3 = rsp_valid; w3 = rsp_we; d3 = rsp_rdata;
        total++; if (v1 !== 1'b0 || v2 !== 1'b0) begin bad++; $display("FAIL lat_early got=%b%b want=00", v1, v2); end
        total++; if (v3 !== 1'b1) begin bad++; $display("FAIL lat_on_time got=%b want=1", v3); end
        total++; if (w3 !== 1'b0 || d3 !== 32'hA1) begin bad++; $display("FAIL lat_rsp got we=%b data=%h want we=0 data=000000a1", w3, d3); end
        wait_drain("latency");
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        rsp_s        e;
        rsp_s        g;
        logic [31:0] addrs [6];
        addrs     = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h2000, 32'h2004};
        rsp_ready = 1'b0;
        acc_cnt   = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) do_req(1'b0, addrs[i], 32'h0);
            end
            begin
                repeat (12) @(posedge clk);
                #2;
                total++; if (acc_cnt != MAXO) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", acc_cnt, MAXO); end
                total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready got=%b want=0", req_ready); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b want=1", busy); end
                total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_valid got=%b want=1", rsp_valid); end
                rsp_ready = 1'b1;
            end
        join
        wait_drain("backpressure");
        total++; if (got_q.size() != 6) begin bad++; $display("FAIL bp_count got=%0d want=6", got_q.size()); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("FAIL bp_order got no response want %h", e.rdata); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin bad++; $display("FAIL bp_order got %h/%b/%b want %h/%b/%b", g.rdata, g.err, g.we, e.rdata, e.err, e.we); end
            end
        end
    endtask

    task automatic test_errors();
        rsp_s e;
        rsp_s g;
        rsp_ready = 1'b1;
        do_req(1'b1, 32'h1002, 32'h1234_5678);
        do_req(1'b0, 32'h0FFC, 32'h0);
        do_req(1'b0, BASE + 32'(DEPTH * 4), 32'h0);
        do_req(1'b0, 32'h1000, 32'h0);
        do_req(1'b0, 32'h1004, 32'h0);
        wait_drain("errors");
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("FAIL err[%0d] got no response want one", k); end
            else begin
                g = got_q.pop_front();
                if (k < 3 && (g.err !== 1'b1 || g.rdata !== 32'h0)) begin
                    bad++; $display("FAIL err_flag[%0d] got err=%b data=%h want err=1 data=0", k, g.err, g.rdata);
                end else if (k >= 3 && g.rdata !== 32'hA0 + 32'(k - 3)) begin
                    bad++; $display("FAIL err_untouched[%0d] got %h want %h", k, g.rdata, 32'hA0 + 32'(k - 3));
                end else if (g !== e) begin
                    bad++; $display("FAIL err[%0d] got %h/%b/%b want %h/%b/%b", k, g.rdata, g.err, g.we, e.rdata, e.err, e.we);
                end
            end
        end
    endtask

    task automatic test_raw();
        rsp_s g;
        rsp_ready = 1'b1;
        do_req(1'b1, 32'h1008, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h1008, 32'h0);
        wait_drain("raw");
        total++;
        if (got_q.size() != 2) begin bad++; $display("FAIL raw_count got=%0d want=2", got_q.size()); end
        else begin
            g = got_q[1];
            if (g.rdata !== 32'hDEAD_BEEF || g.err !== 1'b0 || g.we !== 1'b0)
                begin bad++; $display("FAIL raw_data got %h/%b/%b want deadbeef/0/0", g.rdata, g.err, g.we); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        rsp_s e;
        rsp_s g;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) do_req(1'b1, BASE + 32'(4 * i), $urandom);
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    int          sel;
                    logic [31:0] a;
                    sel = $urandom_range(0, 9);
                    a   = BASE + 32'(4 * $urandom_range(0, 15));
                    if (sel == 0)      a = a + 32'($urandom_range(1, 3));
                    else if (sel == 1) a = a + 32'(DEPTH * 4);
                    else if (sel == 2) a = a - 32'h100;
                    do_req(1'($urandom_range(0, 1)), a, $urandom);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
                rsp_ready = 1'b1;
            end
        join
        wait_drain("random");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("FAIL rand got no response want %h/%b/%b", e.rdata, e.err, e.we); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin bad++; $display("FAIL rand got %h/%b/%b want %h/%b/%b", g.rdata, g.err, g.we, e.rdata, e.err, e.we); end
            end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rand_extra got=%0d want=0", got_q.size()); end
    endtask

    task automatic test_reset_mid();
        rsp_s g;
        rsp_ready = 1'b0;
        do_req(1'b1, 32'h1010, 32'hCAFE_F00D);
        do_req(1'b0, 32'h1000, 32'h0);
        do_req(1'b0, 32'h1004, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_queued got valid=%b busy=%b want 1 1", rsp_valid, busy); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_req_ready got=%b want=0", req_ready); end
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #2;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h1010, 32'h0);
        wait_drain("reset_mid");
        total++;
        if (got_q.size() != 1) begin bad++; $display("FAIL mid_after_count got=%0d want=1", got_q.size()); end
        else begin
            g = got_q.pop_front();
            if (g.rdata !== 32'hCAFE_F00D || g.err !== 1'b0) begin bad++; $display("FAIL mid_after_data got %h err=%b want cafef00d err=0", g.rdata, g.err); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        acc_cnt = 0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic_copy();
        test_latency();
        test_backpressure();
        test_errors();
        test_raw();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish before 500000ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/copy_mem_responder.md
Name: copy_mem_responder

Overview:
- Word-addressed memory target answering the copy engine's read and write requests.
- Other end of the copy engine's memory port: accepts requests with a valid/ready handshake and returns in-order responses after a fixed pipeline latency.
- Out-of-range and misaligned requests get error responses.
- Used as the memory model/target behind copy_engine in subsystem simulation and FPGA bring-up.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte address of word 0.
- DEPTH_WORDS, 2048: number of 32-bit words; covers 0x1000 and 0x2000 regions.
- READ_LATENCY, 2: cycles from request accept to response availability; allowed range 1..4.
- MAX_OUTSTANDING, 4: maximum requests accepted but not yet consumed on the response side.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester consumes response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range or misaligned.
- rsp_we  out  1  echo of the request's req_we.
- busy  out  1  any request in pipeline or response queue.

Behaviour:
- Reset (rst=0, async): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_we=0, busy=0.
  - Pipeline and queue are cleared; memory contents are not cleared.
  - req_ready rises on the first clk edge after rst deasserts.
- Accept: request accepted on a clk edge where req_valid & req_ready.
- Address decode: offset = req_addr - BASE_ADDR, 32-bit unsigned wrap.
  - err = (req_addr[1:0] != 0) | (offset >= DEPTH_WORDS*4); index = offset[31:2].
  - Address below BASE_ADDR wraps to a huge offset, so it flags err.
- Write: memory updated on the accept edge; skipped if err. Response follows with rdata=0.
- Read: data sampled at accept and carried through the READ_LATENCY-stage pipeline. Read of err address returns rdata=0.
- Read-after-write to the same word in consecutive accepts returns the new data (memory write precedes read in the same ordering).
- Latency: response enters the queue READ_LATENCY cycles after accept. If the queue was empty, rsp_valid is high on that edge.
- Response queue: FIFO with MAX_OUTSTANDING entries. Responses are strictly in accept order.
- Response handshake: rsp_valid held with stable rsp_* until rsp_ready. Pop on rsp_valid & rsp_ready.
- Credit: inflight = requests in pipeline + queue occupancy.
  - req_ready = (inflight < MAX_OUTSTANDING), computed from registered state, with no combinational path from req_valid or rsp_ready.
  - Full: req_ready=0.
  - Simultaneous accept and pop in one cycle keeps inflight unchanged.
  - Queue can never overflow.
- rsp_ready held low indefinitely: pipeline drains into the queue, then req_ready stays 0. No data is lost.
- busy = (inflight != 0).
- Reset mid-operation: all in-flight responses are discarded; writes already accepted remain in memory.

Optional Feature:
- Macro: COPY_RSP_STALL_EN.
- Defined:
  - A 16-bit LFSR (poly x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle.
  - When LFSR[1:0]==2'b00, req_ready is forced 0 that cycle; this exercises copy_engine backpressure.
  - Latency and ordering rules are unchanged.
- Undefined: no LFSR logic; req_ready purely credit-based.

Decomposition:
- Package copy_pkg: data/address width constants (32), response record fields (rdata, err, we), default BASE_ADDR. Shared with copy_engine.
- Sub-module copy_rsp_fifo: parameterised-depth synchronous FIFO with count, push/pop, and the same async active-low reset. The responder owns memory array, decode, latency pipeline and credit logic.

Test Plan:
- Basic copy
  - Stimulus: preload words 0x1000..0x100C with 0xA0..0xA3; drive copy_engine src=0x1000, dst=0x2000, length=4.
  - Required: done asserts; reads of 0x2000..0x200C return 0xA0..0xA3 with rsp_err=0.
- Latency
  - Stimulus: single read at 0x1004, queue idle, rsp_ready=1.
  - Required: rsp_valid exactly READ_LATENCY=2 cycles after accept; rsp_we=0.
- Backpressure
  - Stimulus: rsp_ready=0, 6 back-to-back reads.
  - Required: exactly 4 accepted, then req_ready=0 and busy=1.
  - Then raise rsp_ready: 4 responses in order, then the remaining 2 accepted and answered.
- Errors
  - Stimulus: write 0x1002 (misaligned), read 0x0FFC, read 0x1000+DEPTH_WORDS*4.
  - Required: each gives rsp_err=1, rsp_rdata=0; no memory word is modified.
- Read-after-write
  - Stimulus: write 0x1008=0xDEADBEEF, read 0x1008 next cycle.
  - Required: read response 0xDEADBEEF.
- Reset mid-operation
  - Stimulus: rst=0 asynchronously with 3 responses queued.
  - Required: rsp_valid=0 and busy=0 immediately; after release, a read of the previously written address returns the written data.
